mul_sched: RTL
==============

# mul_sched

Arbiter and sequencer for the shared shift-add constant-multiply datapath. Up to NREQ requesters each offer an 8-bit operand. The block grants one operand at a time, walks the datapath through its four coefficient phases (×1, ×3, ×7, ×8), and returns each 11-bit product with the requester's ID. It sits between the operand sources and the single multiply resource, so that resource needs no per-requester logic.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 3: width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst, input, 1: reset, synchronous and active-high.
- req_valid, input, NREQ: requester i has an operand pending.
- req_data, input, 8*NREQ: operand of requester i at bits [8i+7:8i].
- req_ready, output, NREQ: one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid, output, 1: product on rsp_data is valid.
- rsp_ready, input, 1: consumer accepts the product this cycle.
- rsp_id, output, IDW: index of the requester that owns the product.
- rsp_phase, output, 2: coefficient index (0:×1, 1:×3, 2:×7, 3:×8).
- rsp_data, output, 11: product, unsigned.
- busy, output, 1: an operand is being sequenced.

## Operation
- States: IDLE, RUN. The phase counter is 2 bits and is only meaningful in RUN.
- IDLE:
  - req_ready is combinational and equals the arbitration winner among asserted req_valid bits.
  - On transfer: latch the operand and the ID, set phase=0, go to RUN.
- RUN:
  - rsp_valid=1. rsp_data is the latched operand × coef[phase].
  - A phase advances only on rsp_valid & rsp_ready. Without rsp_ready, all rsp_* outputs hold stable.
- Phase 3 accepted:
  - If any req_valid is set, a new grant is issued in the same cycle (back-to-back), and RUN restarts at phase 0 with no bubble.
  - Otherwise go to IDLE.
- req_ready is 0 in RUN, except in the phase-3-accepted cycle.
- Arithmetic: coefficients are formed by shifts and adds only (d, (d<<1)+d, (d<<3)-d, d<<3), all zero-extended to 11 bits. The maximum value 2040 (255×8) fits without overflow.
- Arbitration:
  - Round-robin pointer starts at 0 and moves to (granted+1) mod NREQ after each transfer.
  - The winner is the first asserted req_valid at or after the pointer, wrapping around.
- Deasserting req_valid before a grant is allowed. The requester simply loses the slot. The operand must not change while req_valid is set and unserved.
- Reset: rsp_valid=0, rsp_id=0, rsp_phase=0, rsp_data=0, busy=0, req_ready=0, state=IDLE, pointer=0.
- Reset asserted mid-RUN aborts the sequence immediately. No further products are produced for the aborted operand.

## Timing
- Transfer at edge t gives phase-0 product valid in cycle t+1. All rsp_* outputs are registered.
- With rsp_ready held at 1: 4 cycles per operand, sustained throughput of 1 operand every 4 cycles.
- busy=1 from the cycle after a transfer until the cycle after the final accept that has no follow-on grant.
- req_ready is combinational from req_valid, the state, the phase and rsp_ready. The registered outputs have no combinational path from inputs.

## Configuration
- MUL_SCHED_RR_EN defined: round-robin arbitration as above.
- MUL_SCHED_RR_EN undefined:
  - Fixed priority, lowest index wins.
  - Pointer register is removed.
  - Everything else is identical.

## Structure
- Package mul_sched_pkg holds:
  - state enum (IDLE, RUN);
  - coefficient constants (1, 3, 7, 8);
  - operand width 8 and product width 11;
  - phase-count constant 4.
- One sub-module, mul_shift_add: combinational 8-bit operand plus 2-bit phase in, 11-bit product out. It isolates the shared datapath from the sequencer.
- Arbiter and FSM stay in mul_sched.

## Test plan
- Single request: req_valid=4'b0001, data 0xFF, rsp_ready=1. Expect req_ready[0] for 1 cycle, then rsp_data 255, 765, 1785, 2040 on 4 consecutive cycles, rsp_id=0.
- Backpressure: data 0x05, rsp_ready low for 3 cycles at phase 1. Expect rsp_data=15 held stable with rsp_phase=1 held, then 35 and 40 after rsp_ready rises.
- Round-robin (MUL_SCHED_RR_EN defined): all four req_valid held high. Expect grant order 0,1,2,3,0, back-to-back, no idle cycle between phase 3 and the next phase 0.
- Fixed priority (MUL_SCHED_RR_EN undefined): req_valid=4'b1010 held. Expect requester 1 granted every time and requester 3 starved.
- Reset mid-sequence: assert rst during phase 2. Expect all outputs 0 on the next cycle. After release, a new request on requester 2 is granted (pointer reset to 0, first valid at or after 0).
- Zero operand and withdrawn request: data 0x00 gives four products of 0. A req_valid pulse dropped before grant while busy produces no response.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the constant-multiply scheduler.
// MUL_SCHED_RR_EN selects round-robin arbitration in mul_sched.
package mul_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int OPW    = 8;
   localparam int PRODW  = 11;
   localparam int NPHASE = 4;

   localparam int COEF0 = 1;
   localparam int COEF1 = 3;
   localparam int COEF2 = 7;
   localparam int COEF3 = 8;

   localparam logic [1:0] LAST_PHASE = 2'(NPHASE - 1);

endpackage

// File: rtl/mul_shift_add.sv
// Shared shift-add datapath: operand times coefficient of the phase.
// Coefficients x1, x3, x7, x8 built from shifts and adds only.
module mul_shift_add
   import mul_sched_pkg::*;
(
   input  logic [OPW-1:0]   operand,
   input  logic [1:0]       phase,
   output logic [PRODW-1:0] product
);

   logic [PRODW-1:0] d;

   assign d = PRODW'(operand);

   // select the shift-add form for the current coefficient
   always_comb begin
      product = d;
      case (phase)
         2'd0:    product = d;
         2'd1:    product = (d << 1) + d;
         2'd2:    product = (d << 3) - d;
         2'd3:    product = d << 3;
         default: product = d;
      endcase
   end

endmodule

// File: rtl/mul_sched.sv
// Arbiter and phase sequencer in front of the shared multiplier.
// MUL_SCHED_RR_EN: round-robin grant; otherwise fixed lowest-index priority.
module mul_sched
   import mul_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [1:0]        rsp_phase,
   output logic [10:0]       rsp_data,
   output logic              busy
);

   state_t           state, state_n;
   logic [OPW-1:0]   op_q, op_n;
   logic [IDW-1:0]   id_q, id_n;
   logic [1:0]       phase_q, phase_n;
   logic [PRODW-1:0] prod_q, prod_n;
   logic [IDW-1:0]   win;
   logic             win_ok;
   logic             grant_en;
   logic             xfer;

`ifdef MUL_SCHED_RR_EN
   logic [IDW-1:0]    ptr_q, ptr_n;
   logic [2*NREQ-1:0] rot2;

   assign rot2 = {req_valid, req_valid} >> ptr_q;

   // first asserted request at or after the pointer, wrapping
   always_comb begin
      int idx;
      win    = '0;
      win_ok = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_ok && rot2[k]) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            win    = IDW'(idx);
            win_ok = 1'b1;
         end
      end
   end
`else
   // lowest asserted index wins
   always_comb begin
      win    = '0;
      win_ok = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_ok && req_valid[k]) begin
            win    = IDW'(k);
            win_ok = 1'b1;
         end
      end
   end
`endif

   assign grant_en = !rst &&
                     ((state == IDLE) ||
                      (phase_q == LAST_PHASE && rsp_ready));
   assign xfer     = grant_en && win_ok;

   // one-hot grant, only when a slot is free
   always_comb begin
      req_ready = '0;
      if (xfer) req_ready = NREQ'(1) << win;
   end

   // next-state: load on transfer, step phase on accept
   always_comb begin
      state_n = state;
      op_n    = op_q;
      id_n    = id_q;
      phase_n = phase_q;
`ifdef MUL_SCHED_RR_EN
      ptr_n   = ptr_q;
`endif
      if (xfer) begin
         state_n = RUN;
         op_n    = req_data[int'(win)*OPW +: OPW];
         id_n    = win;
         phase_n = 2'd0;
`ifdef MUL_SCHED_RR_EN
         ptr_n   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
`endif
      end else if (state == RUN && rsp_ready) begin
         if (phase_q == LAST_PHASE) state_n = IDLE;
         else phase_n = phase_q + 2'd1;
      end
   end

   mul_shift_add u_dp (
      .operand (op_n),
      .phase   (phase_n),
      .product (prod_n)
   );

   // state and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         id_q    <= '0;
         phase_q <= '0;
         prod_q  <= '0;
`ifdef MUL_SCHED_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         state   <= state_n;
         op_q    <= op_n;
         id_q    <= id_n;
         phase_q <= phase_n;
         prod_q  <= prod_n;
`ifdef MUL_SCHED_RR_EN
         ptr_q   <= ptr_n;
`endif
      end
   end

   assign rsp_valid = (state == RUN);
   assign busy      = (state == RUN);
   assign rsp_id    = id_q;
   assign rsp_phase = phase_q;
   assign rsp_data  = prod_q;

endmodule
